// File: rtl/meep_uart_axil_fifo.sv
// AXI4-Lite register front end for a byte UART: TX/RX FIFOs, status, control and a level interrupt.
// The serializer and deserializer attach through the tx_*/rx_* byte streams.
//
// state  | meaning
// W_IDLE | write channel ready; AW and W accepted together
// W_RESP | write response held on B until bready
// R_IDLE | read channel ready; AR accepted
// R_RESP | read data held on R until rready

module meep_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_push_acc,
    output logic       o_pop_acc,
    output logic       o_last
);
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] w_count;

    assign w_count    = r_wptr - r_rptr;
    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_last     = (w_count == {{AW{1'b0}}, 1'b1});
    assign o_data     = r_mem[r_rptr[AW-1:0]];
    // A flush overrides any same-cycle push or pop; a pop frees room for a push when full.
    assign o_pop_acc  = i_pop && !o_empty && !i_flush;
    assign o_push_acc = i_push && (!o_full || o_pop_acc) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (o_push_acc) r_wptr <= r_wptr + 1'b1;
            if (o_pop_acc)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_push_acc) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

module meep_uart_axil_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst,
    input  logic [12:0] uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic [3:0]  uart_axi_wstrb,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [12:0] uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        uart_irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] SEL_RXFIFO  = 2'd0;
    localparam logic [1:0] SEL_TXFIFO  = 2'd1;
    localparam logic [1:0] SEL_STAT    = 2'd2;
    localparam logic [1:0] SEL_CTRL    = 2'd3;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_RESP } rstate_t;

    wstate_t     r_wstate;
    rstate_t     r_rstate;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_ie;
    logic        r_overrun;
    logic        r_tx_done;
    logic        r_irq;

    logic        w_aw_bad, w_ar_bad;
    logic        w_wr_hs, w_rd_hs, w_wr_en, w_rd_en;
    logic        w_tx_push, w_ctrl_wr, w_tx_flush, w_rx_flush;
    logic        w_rx_pop, w_stat_rd, w_tx_pop;
    logic [7:0]  w_tx_head, w_rx_head;
    logic        w_tx_empty, w_tx_full, w_tx_push_acc, w_tx_pop_acc, w_tx_last;
    logic        w_rx_empty, w_rx_full, w_rx_push_acc, w_rx_pop_acc, w_rx_last;
    logic [31:0] w_stat;
    logic [31:0] w_rdata_nxt;
    logic [1:0]  w_rresp_nxt;
    logic        w_overrun_set, w_tx_done_set;
    logic        w_unused;

    assign w_aw_bad = (uart_axi_awaddr[12:4] != '0) || (uart_axi_awaddr[1:0] != 2'b00);
    assign w_ar_bad = (uart_axi_araddr[12:4] != '0) || (uart_axi_araddr[1:0] != 2'b00);

    assign w_wr_hs = (r_wstate == W_IDLE) && uart_axi_awvalid && uart_axi_wvalid && !chipset_rst;
    assign w_rd_hs = (r_rstate == R_IDLE) && uart_axi_arvalid && !chipset_rst;

    assign uart_axi_awready = w_wr_hs;
    assign uart_axi_wready  = w_wr_hs;
    assign uart_axi_arready = (r_rstate == R_IDLE) && !chipset_rst;

    assign w_wr_en    = w_wr_hs && !w_aw_bad && uart_axi_wstrb[0];
    assign w_rd_en    = w_rd_hs && !w_ar_bad;
    assign w_tx_push  = w_wr_en && (uart_axi_awaddr[3:2] == SEL_TXFIFO);
    assign w_ctrl_wr  = w_wr_en && (uart_axi_awaddr[3:2] == SEL_CTRL);
    assign w_tx_flush = w_ctrl_wr && uart_axi_wdata[0];
    assign w_rx_flush = w_ctrl_wr && uart_axi_wdata[1];
    assign w_rx_pop   = w_rd_en && (uart_axi_araddr[3:2] == SEL_RXFIFO);
    assign w_stat_rd  = w_rd_en && (uart_axi_araddr[3:2] == SEL_STAT);
    assign w_tx_pop   = tx_valid && tx_ready;

    meep_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk      (chipset_clk),
        .i_rst      (chipset_rst),
        .i_push     (w_tx_push),
        .i_pop      (w_tx_pop),
        .i_flush    (w_tx_flush),
        .i_data     (uart_axi_wdata[7:0]),
        .o_data     (w_tx_head),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full),
        .o_push_acc (w_tx_push_acc),
        .o_pop_acc  (w_tx_pop_acc),
        .o_last     (w_tx_last)
    );

    meep_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk      (chipset_clk),
        .i_rst      (chipset_rst),
        .i_push     (rx_valid),
        .i_pop      (w_rx_pop),
        .i_flush    (w_rx_flush),
        .i_data     (rx_data),
        .o_data     (w_rx_head),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full),
        .o_push_acc (w_rx_push_acc),
        .o_pop_acc  (w_rx_pop_acc),
        .o_last     (w_rx_last)
    );

    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_head;

    assign w_stat = {26'h0, r_overrun, r_ie, w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};

    // A byte lost to a flush is not an overrun; only a full FIFO with no pop drops it.
    assign w_overrun_set = rx_valid && !w_rx_push_acc && !w_rx_flush;
    assign w_tx_done_set = w_tx_pop_acc && w_tx_last && !w_tx_push_acc;

    always_comb begin
        w_rdata_nxt = 32'h0;
        w_rresp_nxt = RESP_OKAY;
        if (w_ar_bad) begin
            w_rresp_nxt = RESP_SLVERR;
        end else begin
            case (uart_axi_araddr[3:2])
                SEL_RXFIFO: w_rdata_nxt = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
                SEL_STAT:   w_rdata_nxt = w_stat;
                default:    w_rdata_nxt = 32'h0;
            endcase
        end
    end

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_wr_hs) begin
                    r_wstate <= W_RESP;
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_aw_bad ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: if (uart_axi_bready) begin
                    r_wstate <= W_IDLE;
                    r_bvalid <= 1'b0;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_rd_hs) begin
                    r_rstate <= R_RESP;
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rdata_nxt;
                    r_rresp  <= w_rresp_nxt;
                end
                R_RESP: if (uart_axi_rready) begin
                    r_rstate <= R_IDLE;
                    r_rvalid <= 1'b0;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // A new event in the same cycle as a STAT read wins over the clear.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            r_ie      <= 1'b0;
            r_overrun <= 1'b0;
            r_tx_done <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ie <= uart_axi_wdata[4];
            if (w_overrun_set)      r_overrun <= 1'b1;
            else if (w_stat_rd)     r_overrun <= 1'b0;
            if (w_tx_done_set)      r_tx_done <= 1'b1;
            else if (w_stat_rd)     r_tx_done <= 1'b0;
            r_irq <= r_ie && (!w_rx_empty || r_tx_done || r_overrun);
        end
    end

    assign uart_axi_bvalid = r_bvalid;
    assign uart_axi_bresp  = r_bresp;
    assign uart_axi_rvalid = r_rvalid;
    assign uart_axi_rdata  = r_rdata;
    assign uart_axi_rresp  = r_rresp;
    assign uart_irq        = r_irq;

    assign w_unused = ^{uart_axi_wdata[31:5], uart_axi_wdata[3:2], uart_axi_wstrb[3:1],
                        w_rx_pop_acc, w_rx_last};
endmodule
